// File: rtl/buffer_drain_ctrl.sv
// buffer_drain_ctrl: drains a registered-read input buffer into a 2-entry
// output queue and presents the words in FIFO order on a valid/ready port.
// Optional feature: define DRAIN_COUNT_EN to add drain_count_o, a 16-bit
// wrapping counter of delivered words.
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | no word queued, out_valid_o low
// HALF  | one word queued at the head
// FULL  | two words queued (head + tail), no more reads
module buffer_drain_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  buf_empty_i,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  output logic                  buf_read_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o
`ifdef DRAIN_COUNT_EN
  ,
  output logic [15:0]           drain_count_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t                  state;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            credit;
  logic [DATA_WIDTH-1:0] tail_q;

  // Credit counts queued words plus the word on its way back from the
  // buffer, minus the one leaving this cycle; reads stop at 2 so the queue
  // can never overflow.
  assign occ        = state;
  assign pop        = out_valid_o & out_ready_i;
  assign credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign buf_read_o = !reset && !buf_empty_i && (credit < 3'd2);

  // Occupancy FSM with the head register driving out_data_o directly and
  // out_valid_o registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      inflight    <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      tail_q      <= '0;
    end else begin
      inflight <= buf_read_o;
      case (state)
        EMPTY: begin
          if (inflight) begin
            out_data_o  <= buf_data_i;
            out_valid_o <= 1'b1;
            state       <= HALF;
          end
        end
        HALF: begin
          case ({inflight, pop})
            2'b10: begin
              tail_q <= buf_data_i;
              state  <= FULL;
            end
            2'b01: begin
              out_valid_o <= 1'b0;
              state       <= EMPTY;
            end
            2'b11: begin
              out_data_o <= buf_data_i;
            end
            default: ;
          endcase
        end
        FULL: begin
          // A push here cannot happen while credit gates the reads; the
          // push+pop arm only keeps the queue coherent if it ever did.
          if (pop) begin
            out_data_o <= tail_q;
            if (inflight) begin
              tail_q <= buf_data_i;
            end else begin
              state <= HALF;
            end
          end
        end
        default: begin
          out_valid_o <= 1'b0;
          state       <= EMPTY;
        end
      endcase
    end
  end

`ifdef DRAIN_COUNT_EN
  // Delivered-word counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_count_o <= 16'h0000;
    end else if (pop) begin
      drain_count_o <= drain_count_o + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_buffer_drain_ctrl.sv
// Bench for buffer_drain_ctrl: models the input buffer with a one-cycle
// registered read, applies a table of per-cycle vectors and a few
// hand-written sequences for reset and the optional counter.
module tb_buffer_drain_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        buf_empty_i;
  logic [15:0] buf_data_i = 16'hDEAD;
  logic        buf_read_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_data_o;
`ifdef DRAIN_COUNT_EN
  logic [15:0] drain_count_o;
`endif

  int checks = 0;
  int failures = 0;

  buffer_drain_ctrl #(.DATA_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .buf_empty_i  (buf_empty_i),
    .buf_data_i   (buf_data_i),
    .buf_read_o   (buf_read_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o)
`ifdef DRAIN_COUNT_EN
    ,
    .drain_count_o(drain_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Input buffer model: data appears exactly one cycle after a read,
  // garbage in every other cycle.
  logic [15:0] mem [256];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;
  assign buf_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (buf_read_o) begin
      buf_data_i <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
    end else begin
      buf_data_i <= 16'hDEAD;
    end
  end

  // Protocol monitor: occupancy from port activity, pop count.
  int   occ_m = 0;
  int   pops_total = 0;
  logic prev_read = 1'b0;
  logic mon_pop;

  always @(posedge clk) begin
    if (reset) begin
      occ_m      = 0;
      prev_read  = 1'b0;
      pops_total = 0;
    end else begin
      if (buf_read_o && buf_empty_i) begin
        failures++;
        $display("FAIL read_when_empty: buf_read_o=1 with buf_empty_i=1 at %0t", $time);
      end
      mon_pop = out_valid_o && out_ready_i;
      if (prev_read) begin
        checks++;
        if (occ_m >= 2) begin
          failures++;
          $display("FAIL push_in_full: occupancy %0d, required below 2 at %0t", occ_m, $time);
        end
      end
      occ_m = occ_m + (prev_read ? 1 : 0) - (mon_pop ? 1 : 0);
      if (mon_pop) pops_total++;
      prev_read = buf_read_o;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  typedef struct {
    int          nload;
    logic [15:0] first;
    logic        ready;
    logic        exp_read;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic [15:0] f, input logic r,
                     input logic er, input logic ev, input logic [15:0] ed);
    vec_t v;
    v.nload = n; v.first = f; v.ready = r;
    v.exp_read = er; v.exp_valid = ev; v.exp_data = ed;
    tbl.push_back(v);
  endtask

  initial begin
    // single word
    add(1, 16'h1234, 1, 1, 0, 16'h0000);
    add(0, 16'h0000, 1, 0, 0, 16'h0000);
    add(0, 16'h0000, 1, 0, 1, 16'h1234);
    add(0, 16'h0000, 1, 0, 0, 16'h0000);
    // streaming 1..5
    add(5, 16'h0001, 1, 1, 0, 16'h0000);
    add(0, 16'h0000, 1, 1, 0, 16'h0000);
    add(0, 16'h0000, 1, 1, 1, 16'h0001);
    add(0, 16'h0000, 1, 1, 1, 16'h0002);
    add(0, 16'h0000, 1, 1, 1, 16'h0003);
    add(0, 16'h0000, 1, 0, 1, 16'h0004);
    add(0, 16'h0000, 1, 0, 1, 16'h0005);
    add(0, 16'h0000, 1, 0, 0, 16'h0000);
    // backpressure, 4 words
    add(4, 16'h00A1, 0, 1, 0, 16'h0000);
    add(0, 16'h0000, 0, 1, 0, 16'h0000);
    add(0, 16'h0000, 0, 0, 1, 16'h00A1);
    add(0, 16'h0000, 0, 0, 1, 16'h00A1);
    add(0, 16'h0000, 0, 0, 1, 16'h00A1);
    add(0, 16'h0000, 1, 1, 1, 16'h00A1);
    add(0, 16'h0000, 1, 1, 1, 16'h00A2);
    add(0, 16'h0000, 1, 0, 1, 16'h00A3);
    add(0, 16'h0000, 1, 0, 1, 16'h00A4);
    add(0, 16'h0000, 1, 0, 0, 16'h0000);
    // toggling ready, 3 words
    add(3, 16'h00B1, 0, 1, 0, 16'h0000);
    add(0, 16'h0000, 0, 1, 0, 16'h0000);
    add(0, 16'h0000, 1, 1, 1, 16'h00B1);
    add(0, 16'h0000, 0, 0, 1, 16'h00B2);
    add(0, 16'h0000, 1, 0, 1, 16'h00B2);
    add(0, 16'h0000, 0, 0, 1, 16'h00B3);
    add(0, 16'h0000, 1, 0, 1, 16'h00B3);
    add(0, 16'h0000, 1, 0, 0, 16'h0000);

    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    check("reset_valid", {15'd0, out_valid_o}, 16'h0000);
    check("reset_data", out_data_o, 16'h0000);
    check("reset_read", {15'd0, buf_read_o}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      for (int k = 0; k < tbl[i].nload; k++) load(tbl[i].first + 16'(k));
      out_ready_i = tbl[i].ready;
      #1;
      check($sformatf("row%0d_read", i), {15'd0, buf_read_o}, {15'd0, tbl[i].exp_read});
      check($sformatf("row%0d_valid", i), {15'd0, out_valid_o}, {15'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("row%0d_data", i), out_data_o, tbl[i].exp_data);
    end

    // reset in the cycle after a read strobe, second word still buffered
    @(negedge clk);
    out_ready_i = 1'b0;
    load(16'h00C1);
    load(16'h00C2);
    #1;
    check("rst_pre_read", {15'd0, buf_read_o}, 16'h0001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_read", {15'd0, buf_read_o}, 16'h0000);
    check("rst_mid_valid", {15'd0, out_valid_o}, 16'h0000);
    check("rst_mid_data", out_data_o, 16'h0000);
    wr_ptr = rd_ptr;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready_i = 1'b1;
      #1;
      check($sformatf("post_rst%0d_read", c), {15'd0, buf_read_o}, 16'h0000);
      check($sformatf("post_rst%0d_valid", c), {15'd0, out_valid_o}, 16'h0000);
    end

    // resume from EMPTY after reset
    @(negedge clk);
    load(16'h00D1);
    #1;
    check("resume_read", {15'd0, buf_read_o}, 16'h0001);
    @(negedge clk);
    #1;
    check("resume_wait_valid", {15'd0, out_valid_o}, 16'h0000);
    @(negedge clk);
    #1;
    check("resume_valid", {15'd0, out_valid_o}, 16'h0001);
    check("resume_data", out_data_o, 16'h00D1);
    @(negedge clk);
    #1;
    check("resume_done", {15'd0, out_valid_o}, 16'h0000);

`ifdef DRAIN_COUNT_EN
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("cnt_reset", drain_count_o, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 70000 && pops_total < 65537; cyc++) begin
      @(negedge clk);
      out_ready_i = 1'b1;
      if (8'(wr_ptr - rd_ptr) < 8'd4) load(cyc[15:0]);
      #1;
      if (pops_total == 65535) check("cnt_ffff", drain_count_o, 16'hFFFF);
      if (pops_total == 65536) check("cnt_wrap", drain_count_o, 16'h0000);
      if (pops_total == 65537) check("cnt_one", drain_count_o, 16'h0001);
    end
    checks++;
    if (pops_total < 65537) begin
      failures++;
      $display("FAIL cnt_timeout: pops %0d, required 65537", pops_total);
    end
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
